uart_tx_fifo_drain: RTL and testbench

//  Transmit-side consumer of the 128x8 UART FIFO: pops bytes through the FIFO's active-low read strobe
//  and serialises them onto the UART TX line (start, 7/8 data LSB-first, optional parity, 1 stop).

---
 rtl/uart_tx_fifo_drain_pkg.sv | 23 ++
 rtl/uart_tx_fifo_drain_bit_timer.sv | 49 ++++
 rtl/uart_tx_fifo_drain.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain_pkg
// Shared definitions for the UART transmit FIFO drain: transmitter FSM state
// encoding and the default bit timing / FIFO data width.
// The PARITY state is always present in the encoding. It is only reachable
// when the top level is built with UART_TX_PARITY_EN defined.
// -----------------------------------------------------------------------------
package uart_tx_fifo_drain_pkg;

  // Default number of baud_tick pulses per serial bit (16x oversampled baud).
  localparam int unsigned DEF_TICKS_PER_BIT = 16;
  // Default FIFO data width; 7-bit frames use the low DATA_WIDTH-1 bits.
  localparam int unsigned DEF_DATA_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_drain_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Counts baud_tick pulses within one serial bit. It flags the tick that ends
// the bit, which is the tick on which the counter wraps from
// TICKS_PER_BIT-1 back to 0.
// Ports:
//   clock     in  system clock
//   reset_n   in  asynchronous active-low reset
//   baud_tick in  one-clock enable at 16x baud
//   clear     in  hold the counter at 0 (transmitter idle)
//   bit_end   out high on the baud_tick that completes the current bit
// -----------------------------------------------------------------------------
module uart_tx_bit_timer
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic baud_tick,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (baud_tick) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign bit_end = baud_tick && !clear && (cnt_q == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// Transmit-side consumer of the UART TX FIFO. It pops bytes through the
// FIFO's active-low read strobe into a one-byte holding register, then
// serialises each byte onto tx. A frame is a start bit, 7 or 8 data bits sent
// LSB first, an optional parity bit and one stop bit. The holding register is
// refilled while a frame is on the line, so consecutive frames are sent
// back-to-back.
//
// Build option: define UART_TX_PARITY_EN to include the PARITY state. Without
// it, parity_en and odd_n_even are accepted but ignored, and frames never
// carry a parity bit.
//
// Ports:
//   clock        in   system clock, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   baud_tick    in   one-clock enable at 16x baud
//   fifo_empty   in   FIFO empty flag
//   fifo_data    in   FIFO registered read data (valid 2 clocks after strobe)
//   fifo_read_n  out  FIFO read strobe, active low, one clock per byte
//   bit8         in   1 = 8 data bits, 0 = 7 data bits
//   parity_en    in   1 = append parity bit (UART_TX_PARITY_EN builds only)
//   odd_n_even   in   1 = odd parity, 0 = even
//   tx           out  serial output, idle high
//   tx_busy      out  high from first START tick through end of STOP
//   tx_done      out  one-clock pulse after a STOP bit completes
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  baud_tick,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_n,
  input  logic                  bit8,
  input  logic                  parity_en,
  input  logic                  odd_n_even,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX_FULL  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX_SHORT = IW'(DATA_WIDTH - 2);

  tx_state_e             state_q, state_d;
  logic                  rd_n_q, rd_n_d;
  logic [1:0]            pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [IW-1:0]         last_idx_q, last_idx_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] par_mask;
`else
  logic                  unused_cfg;
  assign unused_cfg = parity_en ^ odd_n_even;
`endif

  // Bit timing: the counter is held at 0 while idle. The START bit therefore
  // lasts exactly TICKS_PER_BIT ticks after the loading tick.
  uart_tx_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .baud_tick(baud_tick),
    .clear    (state_q == ST_IDLE),
    .bit_end  (bit_end)
  );

  // Fetch pipe. pipe_q[0] marks C1 and pipe_q[1] marks C2 after a strobe.
  // While a strobe is in flight, or while hold is full, no new strobe is
  // issued. This also covers the FIFO's lag in updating its empty flag.
  always_comb begin
    pipe_d       = {pipe_q[0], ~rd_n_q};
    rd_n_d       = ~(~hold_valid_q & ~fifo_empty & rd_n_q & ~(|pipe_q));
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (pipe_q[1]) begin
      hold_d       = fifo_data;
      hold_valid_d = 1'b1;
    end
    // A capture and a load cannot coincide: a strobe is only issued while
    // hold is empty, and a load needs hold to be full.
    if (load) begin
      hold_valid_d = 1'b0;
    end
  end

  // Transmitter FSM. Frame format settings are latched at load so that
  // changes made mid-frame only affect the next frame.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    done_d     = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    par_mask   = '1;
    if (!bit8) begin
      par_mask[DATA_WIDTH-1] = 1'b0;
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (baud_tick && hold_valid_q) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == last_idx_q) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // With a byte already held, the next START begins on this same
          // tick, so no idle bit appears between frames.
          if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d    = ST_START;
      shift_d    = hold_q;
      bit_idx_d  = '0;
      last_idx_d = bit8 ? LAST_IDX_FULL : LAST_IDX_SHORT;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en;
      par_bit_d  = (^(hold_q & par_mask)) ^ odd_n_even;
`endif
    end
  end

  // tx decodes registered state only, so an asynchronous reset returns the
  // line high immediately.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = par_bit_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_done     = done_q;
  assign fifo_read_n = rd_n_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rd_n_q       <= 1'b1;
      pipe_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      last_idx_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_n_q       <= rd_n_d;
      pipe_q       <= pipe_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      last_idx_q   <= last_idx_d;
      done_q       <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
// Bench for uart_tx_fifo_drain.
// A queue-based FIFO model provides the byte source, with a 2-clock read
// latency. A frame model builds the expected bit list for each byte from the
// UART framing rules. A tick-sampling receiver compares every bit of every
// frame, and also checks read strobes, tx_done and tx_busy.
// Parity expectations follow UART_TX_PARITY_EN, exactly as the DUT build does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

  localparam int TPB = 16;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_n;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_drain #(
    .TICKS_PER_BIT(16),
    .DATA_WIDTH   (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read_n(fifo_read_n),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected frame from the UART rules: start 0, data LSB first, optional
  // parity giving even/odd total ones, stop 1.
  function automatic frame_t make_frame(input logic [7:0] b, input logic b8,
                                        input logic pen, input logic odd);
    frame_t f;
    int     nd;
    int     ones;
    nd     = b8 ? 8 : 7;
    f.bits = '0;
    f.len  = 1;
    ones   = 0;
    for (int i = 0; i < nd; i++) begin
      f.bits[f.len] = b[i];
      f.len++;
      if (b[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    if (pen) begin
      f.bits[f.len] = ((ones % 2) == 1) ^ odd;
      f.len++;
    end
`else
    if (pen && odd && ones < 0) f.len = 0;
`endif
    f.bits[f.len] = 1'b1;
    f.len++;
    return f;
  endfunction

  // FIFO model and expectation queue
  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];
  logic       rd_pend = 1'b0;
  logic       stage_v = 1'b0;
  logic [7:0] stage = 8'h00;

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    exp_q.push_back(make_frame(b, bit8, parity_en, odd_n_even));
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    if (stage_v) begin
      fifo_data = stage;
      stage_v   = 1'b0;
    end
    if (rd_pend) begin
      rd_pend = 1'b0;
      check_eq("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) begin
        stage   = fifo_q.pop_front();
        stage_v = 1'b1;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  int unsigned tick_gap_max = 2;
  initial forever begin
    @(posedge clock);
    #1;
    baud_tick = ($urandom_range(0, tick_gap_max) == 0);
  end

  // Monitor / receiver, sampled on the falling edge
  int     cyc = 0;
  int     tick_no = 0;
  int     prev_tick_cyc = -100;
  int     prev2_tick_cyc = -100;
  bit     strobe_seen = 0;
  int     last_strobe_cyc = 0;
  int     n_strobe = 0;
  int     n_done = 0;
  int     n_frames = 0;
  bit     rx_active = 0;
  frame_t cur;
  int     rx_cnt = 0;
  logic [15:0] smp = '0;
  int     last_end_tick = -100;
  bit     contig_chk = 0;
  int     contig_base = 0;
  bit     lat_arm = 0;
  bit     lat_chk = 0;
  int     lat_strobe = 0;
  logic   exp_bit;

  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset_n) begin
      rx_active = 0;
      continue;
    end
    if (!fifo_read_n) begin
      if (strobe_seen) check_eq("strobe_gap_ge3", (cyc - last_strobe_cyc) >= 3, 1);
      strobe_seen     = 1;
      last_strobe_cyc = cyc;
      n_strobe++;
      rd_pend = 1'b1;
      if (lat_arm) begin
        lat_strobe = cyc;
        lat_arm    = 0;
      end
    end
    if (tx_done) n_done++;
    if (baud_tick) begin
      if (rx_active) begin
        smp = {smp[14:0], tx};
        rx_cnt++;
        if (rx_cnt % TPB == 0) begin
          exp_bit = cur.bits[rx_cnt / TPB - 1];
          check_eq("frame_bit", smp, {16{exp_bit}});
          if (rx_cnt / TPB == cur.len) begin
            rx_active     = 0;
            n_frames++;
            last_end_tick = tick_no;
          end
        end
      end else if (tx == 1'b0) begin
        check_eq("start_expected", exp_q.size() != 0, 1);
        check_eq("busy_at_start", tx_busy, 1);
        if (contig_chk && n_frames > contig_base)
          check_eq("no_idle_gap", tick_no - last_end_tick, 1);
        if (lat_chk) begin
          check_eq("first_start_latency",
                   (prev_tick_cyc >= lat_strobe + 3) && (prev2_tick_cyc < lat_strobe + 3), 1);
          lat_chk = 0;
        end
        if (exp_q.size() != 0) begin
          cur       = exp_q.pop_front();
          rx_active = 1;
          rx_cnt    = 1;
          smp       = {15'b0, tx};
        end
      end
      prev2_tick_cyc = prev_tick_cyc;
      prev_tick_cyc  = cyc;
      tick_no++;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_frames < target && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, n_frames, target);
    repeat (20) step();
  endtask

  int s0, d0, f0, viol, nb, k;

  initial begin
    // reset values
    repeat (3) step();
    check_eq("rst_tx", tx, 1);
    check_eq("rst_read_n", fifo_read_n, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_done", tx_done, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();

    // 1: single 0xA5, 8N1; config flipped mid-frame must not matter
    s0 = n_strobe; d0 = n_done; f0 = n_frames;
    bit8 = 1; parity_en = 0; odd_n_even = 0;
    lat_arm = 1; lat_chk = 1;
    push_byte(8'hA5);
    k = 0;
    while (!rx_active && k < 2000) begin step(); k++; end
    check_eq("t1_started", rx_active, 1);
    bit8 = 0; parity_en = 1; odd_n_even = 1;
    wait_frames("t1_frames", f0 + 1, 4000);
    check_eq("t1_strobes", n_strobe - s0, 1);
    check_eq("t1_done", n_done - d0, 1);

    // 2: 0x55, 7 bits, even parity (parity bit only in UART_TX_PARITY_EN builds)
    s0 = n_strobe; d0 = n_done; f0 = n_frames;
    bit8 = 0; parity_en = 1; odd_n_even = 0;
    push_byte(8'h55);
    wait_frames("t2_frames", f0 + 1, 4000);
    check_eq("t2_done", n_done - d0, 1);

    // 3: three bytes, frames contiguous
    s0 = n_strobe; d0 = n_done; f0 = n_frames;
    bit8 = 1; parity_en = 0;
    contig_chk = 1; contig_base = n_frames;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    wait_frames("t3_frames", f0 + 3, 8000);
    contig_chk = 0;
    check_eq("t3_strobes", n_strobe - s0, 3);
    check_eq("t3_done", n_done - d0, 3);

    // 4: empty FIFO for 1000 clocks
    s0 = n_strobe; viol = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_read_n !== 1'b1) viol++;
    end
    check_eq("t4_idle_viol", viol, 0);
    check_eq("t4_strobes", n_strobe - s0, 0);

    // 5: reset during data bit 3; held byte is dropped, remaining byte sent
    bit8 = 1; parity_en = 0;
    push_byte(8'hC3); push_byte(8'h3C); push_byte(8'h96);
    k = 0;
    while (!(rx_active && rx_cnt >= 4 * TPB + 8) && k < 4000) begin step(); k++; end
    check_eq("t5_in_bit3", rx_active && rx_cnt >= 4 * TPB + 8, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx, 1);
    check_eq("t5_rst_read_n", fifo_read_n, 1);
    check_eq("t5_rst_busy", tx_busy, 0);
    check_eq("t5_rst_done", tx_done, 0);
    exp_q.delete();
    rd_pend = 1'b0;
    stage_v = 1'b0;
    repeat (4) step();
    foreach (fifo_q[i]) exp_q.push_back(make_frame(fifo_q[i], bit8, parity_en, odd_n_even));
    s0 = n_strobe; d0 = n_done; f0 = n_frames;
    reset_n = 1'b1;
    wait_frames("t5_frames", f0 + 1, 4000);
    check_eq("t5_strobes", n_strobe - s0, 1);
    check_eq("t5_done", n_done - d0, 1);

    // 6: parity requested; frame length follows the build option
    d0 = n_done; f0 = n_frames;
    bit8 = 1; parity_en = 1; odd_n_even = 1;
    push_byte(8'h81);
    wait_frames("t6_frames", f0 + 1, 4000);
    check_eq("t6_done", n_done - d0, 1);

    // random batches
    for (int b = 0; b < 6; b++) begin
      tick_gap_max = $urandom_range(0, 3);
      bit8         = 1'($urandom);
      parity_en    = 1'($urandom);
      odd_n_even   = 1'($urandom);
      nb           = $urandom_range(1, 5);
      s0 = n_strobe; d0 = n_done; f0 = n_frames;
      for (int i = 0; i < nb; i++) push_byte(8'($urandom));
      wait_frames("rnd_frames", f0 + nb, 9000);
      check_eq("rnd_strobes", n_strobe - s0, nb);
      check_eq("rnd_done", n_done - d0, nb);
      check_eq("rnd_exp_drained", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
